// File: rtl/rv32i_soc_if.sv
// Data-memory bus between the RV32I core and its data memory.
// The master drives address, write data and byte strobes; the slave returns read data combinationally.
interface rv32i_soc_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic [31:0] rdata;

  modport master (output addr, output wdata, output wstrb, input rdata);
  modport slave  (input addr, input wdata, input wstrb, output rdata);
endinterface

// File: rtl/rv32i_soc.sv
// Minimal Harvard SoC: single-cycle RV32I core, instruction memory and byte-writable data memory.
// Programs and data are loaded, and results read, through the fixed hierarchy paths below.
module Imem #(
  parameter int SIZE_IN_WORDS = 1024
) (
  input  logic [31:0] addr_i,
  output logic [31:0] inst_o
);
  localparam int AW = $clog2(SIZE_IN_WORDS);

  logic [31:0]   mem [0:SIZE_IN_WORDS-1];
  logic [AW-1:0] wordIdx;
  logic          unusedAddrBits;

  assign wordIdx        = AW'(addr_i[31:2] % SIZE_IN_WORDS);
  assign unusedAddrBits = ^addr_i[1:0];
  assign inst_o         = mem[wordIdx];
endmodule

module Dmem #(
  parameter int SIZE_IN_WORDS = 1024
) (
  input logic        clk,
  rv32i_soc_if.slave bus
);
  localparam int AW = $clog2(SIZE_IN_WORDS);

  logic [31:0]   mem [0:SIZE_IN_WORDS-1];
  logic [AW-1:0] wordIdx;
  logic          unusedAddrBits;

  // Lane selection is done by the core; misaligned addresses fall onto the aligned word.
  assign wordIdx        = AW'(bus.addr[31:2] % SIZE_IN_WORDS);
  assign unusedAddrBits = ^bus.addr[1:0];
  assign bus.rdata      = mem[wordIdx];

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (bus.wstrb[i]) mem[wordIdx][8*i +: 8] <= bus.wdata[8*i +: 8];
    end
  end
endmodule

module RegisterFile (
  input  logic        clk,
  input  logic [4:0]  rs1Addr_i,
  input  logic [4:0]  rs2Addr_i,
  output logic [31:0] rs1Data_o,
  output logic [31:0] rs2Data_o,
  input  logic        we_i,
  input  logic [4:0]  rdAddr_i,
  input  logic [31:0] rdData_i
);
  logic [31:0] mem [0:31];

  assign rs1Data_o = (rs1Addr_i == 5'd0) ? 32'd0 : mem[rs1Addr_i];
  assign rs2Data_o = (rs2Addr_i == 5'd0) ? 32'd0 : mem[rs2Addr_i];

  always_ff @(posedge clk) begin
    if (we_i && (rdAddr_i != 5'd0)) mem[rdAddr_i] <= rdData_i;
  end
endmodule

module Processor #(
  parameter logic [31:0] RESET_PC_VALUE = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  output logic [31:0]  instAddr_o,
  input  logic [31:0]  inst_i,
  rv32i_soc_if.master  dbus
);
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_JALR   = 7'b1100111;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [31:0] EBREAK    = 32'h0010_0073;

  logic [31:0] pc_q, pc_d;
  logic        halt_q, halt_d;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] immI, immS, immB, immU, immJ;
  logic [31:0] rs1Data, rs2Data, rdData;
  logic        rdWe;
  logic        isEbreak, active;
  logic [31:0] pcPlus4, aluB, aluResult, memAddr;
  logic        aluAlt, branchTaken;
  logic [7:0]  byteVal;
  logic [15:0] halfVal;
  logic [31:0] loadData, storeData;
  logic [3:0]  storeStrb;

  assign opcode = inst_i[6:0];
  assign rd     = inst_i[11:7];
  assign funct3 = inst_i[14:12];
  assign rs1    = inst_i[19:15];
  assign rs2    = inst_i[24:20];

  assign immI = {{20{inst_i[31]}}, inst_i[31:20]};
  assign immS = {{20{inst_i[31]}}, inst_i[31:25], inst_i[11:7]};
  assign immB = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
  assign immU = {inst_i[31:12], 12'd0};
  assign immJ = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

  RegisterFile register_file_0 (
    .clk       (clk),
    .rs1Addr_i (rs1),
    .rs2Addr_i (rs2),
    .rs1Data_o (rs1Data),
    .rs2Data_o (rs2Data),
    .we_i      (rdWe),
    .rdAddr_i  (rd),
    .rdData_i  (rdData)
  );

  function automatic logic [31:0] aluCompute(input logic [2:0] f3, input logic alt,
                                             input logic [31:0] a, input logic [31:0] b);
    logic signed [31:0] sra;
    sra = $signed(a) >>> b[4:0];
    case (f3)
      3'b000:  return alt ? (a - b) : (a + b);
      3'b001:  return a << b[4:0];
      3'b010:  return {31'd0, $signed(a) < $signed(b)};
      3'b011:  return {31'd0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return alt ? sra : (a >> b[4:0]);
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  // The subtract/arithmetic-shift bit only means something for register ops and SRAI.
  assign aluAlt    = (opcode == OP_REG) ? inst_i[30] : ((funct3 == 3'b101) && inst_i[30]);
  assign aluB      = (opcode == OP_REG) ? rs2Data : immI;
  assign aluResult = aluCompute(funct3, aluAlt, rs1Data, aluB);
  assign pcPlus4   = pc_q + 32'd4;
  assign memAddr   = rs1Data + ((opcode == OP_STORE) ? immS : immI);
  assign isEbreak  = (inst_i == EBREAK);
  assign active    = !reset && !halt_q && !isEbreak;

  always_comb begin
    case (funct3)
      3'b000:  branchTaken = (rs1Data == rs2Data);
      3'b001:  branchTaken = (rs1Data != rs2Data);
      3'b100:  branchTaken = ($signed(rs1Data) < $signed(rs2Data));
      3'b101:  branchTaken = ($signed(rs1Data) >= $signed(rs2Data));
      3'b110:  branchTaken = (rs1Data < rs2Data);
      3'b111:  branchTaken = (rs1Data >= rs2Data);
      default: branchTaken = 1'b0;
    endcase
  end

  assign byteVal = dbus.rdata[{memAddr[1:0], 3'b000} +: 8];
  assign halfVal = dbus.rdata[{memAddr[1], 4'b0000} +: 16];

  always_comb begin
    case (funct3)
      3'b000:  loadData = {{24{byteVal[7]}}, byteVal};
      3'b100:  loadData = {24'd0, byteVal};
      3'b001:  loadData = {{16{halfVal[15]}}, halfVal};
      3'b101:  loadData = {16'd0, halfVal};
      default: loadData = dbus.rdata;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        storeData = {4{rs2Data[7:0]}};
        storeStrb = 4'b0001 << memAddr[1:0];
      end
      2'b01: begin
        storeData = {2{rs2Data[15:0]}};
        storeStrb = memAddr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        storeData = rs2Data;
        storeStrb = 4'b1111;
      end
    endcase
  end

  assign dbus.addr  = memAddr;
  assign dbus.wdata = storeData;
  assign instAddr_o = pc_q;

  // Anything not listed (FENCE, ECALL, unknown) falls through as a NOP.
  always_comb begin
    pc_d       = pcPlus4;
    halt_d     = halt_q | isEbreak;
    rdWe       = 1'b0;
    rdData     = aluResult;
    dbus.wstrb = 4'b0000;
    case (opcode)
      OP_LUI:    begin rdWe = 1'b1; rdData = immU; end
      OP_AUIPC:  begin rdWe = 1'b1; rdData = pc_q + immU; end
      OP_JAL:    begin rdWe = 1'b1; rdData = pcPlus4; pc_d = pc_q + immJ; end
      OP_JALR:   begin rdWe = 1'b1; rdData = pcPlus4; pc_d = (rs1Data + immI) & ~32'd1; end
      OP_BRANCH: if (branchTaken) pc_d = pc_q + immB;
      OP_LOAD:   begin rdWe = 1'b1; rdData = loadData; end
      OP_STORE:  dbus.wstrb = storeStrb;
      OP_IMM:    rdWe = 1'b1;
      OP_REG:    rdWe = 1'b1;
      default:   ;
    endcase
    if (!active) begin
      pc_d       = pc_q;
      rdWe       = 1'b0;
      dbus.wstrb = 4'b0000;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q   <= RESET_PC_VALUE;
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
    end
  end
endmodule

module rv32i_soc #(
  parameter logic [31:0] RESET_PC_VALUE     = 32'h0000_0000,
  parameter int          IMEM_SIZE_IN_WORDS = 1024,
  parameter int          DMEM_SIZE_IN_WORDS = 1024
) (
  input logic clk,
  input logic reset
);
  wire [31:0] inst_from_imem;
  logic [31:0] pcToImem;

  rv32i_soc_if dbus ();

  Imem #(.SIZE_IN_WORDS(IMEM_SIZE_IN_WORDS)) imem_0 (
    .addr_i (pcToImem),
    .inst_o (inst_from_imem)
  );

  Dmem #(.SIZE_IN_WORDS(DMEM_SIZE_IN_WORDS)) dmem_0 (
    .clk (clk),
    .bus (dbus.slave)
  );

  Processor #(.RESET_PC_VALUE(RESET_PC_VALUE)) processor_0 (
    .clk        (clk),
    .reset      (reset),
    .instAddr_o (pcToImem),
    .inst_i     (inst_from_imem),
    .dbus       (dbus.master)
  );
endmodule

// File: tb/tb_rv32i_soc.sv
// Directed-program bench for rv32i_soc: programs are assembled into IMEM at 0x50 and
// results are read back from DMEM and the register file through the fixed hierarchy.
module tb_rv32i_soc;
  localparam logic [31:0] RESET_PC = 32'h0000_0050;
  localparam logic [31:0] EBREAK   = 32'h0010_0073;
  localparam int BASE  = 20;
  localparam int OPI   = 'h13;
  localparam int LOAD  = 'h03;
  localparam int LUI   = 'h37;
  localparam int AUIPC = 'h17;
  localparam int JALR  = 'h67;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  int          vectorCount = 0;
  int          missCount = 0;
  logic [31:0] progQ[$];

  rv32i_soc_if busMon ();

  rv32i_soc #(
    .RESET_PC_VALUE     (RESET_PC),
    .IMEM_SIZE_IN_WORDS (1024),
    .DMEM_SIZE_IN_WORDS (1024)
  ) dut (
    .clk   (clk),
    .reset (reset)
  );

  assign busMon.addr  = dut.dbus.addr;
  assign busMon.wdata = dut.dbus.wdata;
  assign busMon.wstrb = dut.dbus.wstrb;
  assign busMon.rdata = dut.dbus.rdata;

  always #5 clk = ~clk;

  function automatic logic [31:0] encI(input int op, input int f3, input int rd, input int rs1, input int imm);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] encS(input int f3, input int rs2, input int rs1, input int imm);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction

  function automatic logic [31:0] encR(input int f7, input int f3, input int rd, input int rs1, input int rs2);
    return {f7[6:0], rs2[4:0], rs1[4:0], f3[2:0], rd[4:0], 7'b0110011};
  endfunction

  function automatic logic [31:0] encB(input int f3, input int rs1, input int rs2, input int imm);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] encU(input int op, input int rd, input int imm20);
    return {imm20[19:0], rd[4:0], op[6:0]};
  endfunction

  function automatic logic [31:0] encJ(input int rd, input int imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    vectorCount++;
    if (observed !== expected) begin
      missCount++;
      $display("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Reset is raised before IMEM is rewritten so the old program cannot store on the way out.
  task automatic applyStimulus();
    reset = 1'b1;
    foreach (progQ[i]) dut.imem_0.mem[BASE+i] = progQ[i];
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic runCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    // Reset vector lands directly on ebreak and must stay there.
    progQ = {EBREAK, encI(OPI, 0, 5, 0, 1)};
    applyStimulus();
    checkOutput("reset_fetch", dut.inst_from_imem, EBREAK);
    runCycles(5);
    checkOutput("halt_hold", dut.inst_from_imem, EBREAK);
    checkOutput("halt_no_store", {28'd0, busMon.wstrb}, 32'd0);

    // ALU and word stores.
    dut.dmem_0.mem[0] <= 32'hDEAD_BEEF;
    dut.dmem_0.mem[1] <= 32'hDEAD_BEEF;
    progQ = {encI(OPI, 0, 1, 0, 5), encI(OPI, 0, 2, 0, -3), encR(0, 0, 3, 1, 2),
             encR('h20, 0, 4, 1, 2), encS(2, 3, 0, 0), encS(2, 4, 0, 4), EBREAK};
    applyStimulus();
    runCycles(5);
    checkOutput("alu_cycle5", dut.inst_from_imem, progQ[5]);
    runCycles(1);
    checkOutput("alu_cycle6", dut.inst_from_imem, EBREAK);
    runCycles(2);
    checkOutput("alu_dmem0", dut.dmem_0.mem[0], 32'h0000_0002);
    checkOutput("alu_dmem1", dut.dmem_0.mem[1], 32'h0000_0008);
    checkOutput("alu_x2", dut.processor_0.register_file_0.mem[2], 32'hFFFF_FFFD);
    checkOutput("alu_x4", dut.processor_0.register_file_0.mem[4], 32'h0000_0008);
    checkOutput("alu_halt_no_store", {28'd0, busMon.wstrb}, 32'd0);

    // Byte and halfword loads/stores with sign and zero extension.
    dut.dmem_0.mem[0] <= 32'h8081_F0F1;
    dut.dmem_0.mem[2] <= 32'hAAAA_AAAA;
    dut.dmem_0.mem[3] <= 32'hAAAA_AAAA;
    dut.dmem_0.mem[4] <= 32'hAAAA_AAAA;
    dut.dmem_0.mem[5] <= 32'h1111_2222;
    dut.dmem_0.mem[6] <= 32'h0000_0000;
    progQ = {encI(LOAD, 0, 1, 0, 0), encI(LOAD, 4, 2, 0, 1), encI(LOAD, 1, 3, 0, 2),
             encI(LOAD, 5, 4, 0, 2), encS(2, 1, 0, 8), encS(2, 2, 0, 12), encS(2, 3, 0, 16),
             encS(1, 4, 0, 22), encS(0, 1, 0, 25), encS(0, 0, 0, 0), EBREAK};
    applyStimulus();
    runCycles(14);
    checkOutput("lb_sext", dut.dmem_0.mem[2], 32'hFFFF_FFF1);
    checkOutput("lbu_zext", dut.dmem_0.mem[3], 32'h0000_00F0);
    checkOutput("lh_sext", dut.dmem_0.mem[4], 32'hFFFF_8081);
    checkOutput("sb_lane0", dut.dmem_0.mem[0], 32'h8081_F000);
    checkOutput("sh_upper", dut.dmem_0.mem[5], 32'h8081_2222);
    checkOutput("sb_lane1", dut.dmem_0.mem[6], 32'h0000_F100);
    checkOutput("lhu_zext", dut.processor_0.register_file_0.mem[4], 32'h0000_8081);

    // Sum 1..10 with a backward bne, then taken branches that must skip their fall-through.
    progQ = {encI(OPI, 0, 1, 0, 0), encI(OPI, 0, 2, 0, 10), encR(0, 0, 1, 1, 2),
             encI(OPI, 0, 2, 2, -1), encB(1, 2, 0, -8), encI(OPI, 0, 6, 0, 0),
             encI(OPI, 0, 7, 0, -1), encB(6, 0, 7, 8), encI(OPI, 0, 6, 6, 1),
             encB(4, 7, 0, 8), encI(OPI, 0, 6, 6, 2), encB(5, 7, 0, 8),
             encI(OPI, 0, 6, 6, 4), encS(2, 1, 0, 20), encS(2, 6, 0, 24), EBREAK};
    applyStimulus();
    runCycles(60);
    checkOutput("loop_sum", dut.dmem_0.mem[5], 32'h0000_0037);
    checkOutput("branch_skips", dut.dmem_0.mem[6], 32'h0000_0004);
    checkOutput("loop_halt", dut.inst_from_imem, EBREAK);

    // LUI/AUIPC/JAL/JALR; the odd jalr offset checks the low-bit clear via a later auipc.
    progQ = {encU(LUI, 1, 'h12345), encU(AUIPC, 2, 0), encJ(3, 8), encJ(0, 16),
             encI(JALR, 0, 5, 3, 1), encI(OPI, 0, 0, 0, 0), encI(OPI, 0, 0, 0, 0),
             encU(AUIPC, 6, 0), EBREAK};
    applyStimulus();
    runCycles(6);
    checkOutput("jump_halt", dut.inst_from_imem, EBREAK);
    checkOutput("lui_x1", dut.processor_0.register_file_0.mem[1], 32'h1234_5000);
    checkOutput("auipc_x2", dut.processor_0.register_file_0.mem[2], 32'h0000_0054);
    checkOutput("jal_link", dut.processor_0.register_file_0.mem[3], 32'h0000_005C);
    checkOutput("jalr_link", dut.processor_0.register_file_0.mem[5], 32'h0000_0064);
    checkOutput("jalr_target", dut.processor_0.register_file_0.mem[6], 32'h0000_006C);

    // x0 stays zero; reset mid-loop restarts the program but keeps register contents.
    dut.dmem_0.mem[0] <= 32'hFFFF_FFFF;
    dut.processor_0.register_file_0.mem[8] <= 32'd0;
    progQ = {encI(OPI, 0, 0, 0, 7), encS(2, 0, 0, 0), encI(OPI, 0, 8, 8, 1), encJ(0, -4)};
    applyStimulus();
    runCycles(2);
    checkOutput("x0_store", dut.dmem_0.mem[0], 32'h0000_0000);
    runCycles(6);
    checkOutput("loop_count", dut.processor_0.register_file_0.mem[8], 32'd3);
    reset = 1'b1;
    runCycles(1);
    checkOutput("reset_midrun_pc", dut.inst_from_imem, progQ[0]);
    checkOutput("reset_blocks_write", dut.processor_0.register_file_0.mem[8], 32'd3);
    reset = 1'b0;
    runCycles(3);
    checkOutput("regs_retained", dut.processor_0.register_file_0.mem[8], 32'd4);

    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end
endmodule
